execute_stage_mips: RTL and testbench

// - EX stage of the 5-stage MIPS pipeline; sits between decode and the memory-access stage, feeding its *_Execute inputs.
// - Selects forwarded operands, computes the ALU result, and registers results and controls into the EX/MEM pipeline register.
// - Hosts an iterative 32-cycle signed MULT/DIV unit with HI/LO; stalls upstream while busy.

---
 rtl/execute_stage_mips.sv | 220 ++++++++++++++++++++++
 tb/tb_execute_stage_mips.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_mips.sv
// EX stage of the 5-stage MIPS pipeline: operand forwarding, ALU and the EX/MEM pipeline register.
// Defining MIPS_MULDIV_EN adds an iterative signed MULT/DIV unit with HI/LO that stalls upstream while busy.
module execute_stage_mips #(
  parameter int DATA_WIDTH    = 32,
  parameter int MULDIV_CYCLES = 32
) (
  input  logic                  clock,
  input  logic                  resetMachine,
  input  logic [DATA_WIDTH-1:0] dataReadRegister1_Decode,
  input  logic [DATA_WIDTH-1:0] dataReadRegister2_Decode,
  input  logic [DATA_WIDTH-1:0] immediateExtended_Decode,
  input  logic [3:0]            aluControl_Decode,
  input  logic                  controlSignalAluSource_Decode,
  input  logic                  enableWriteRegisterFile_Decode,
  input  logic [4:0]            addressWriteRegisterFile_Decode,
  input  logic                  controlSignalWriteFromDataMemoryRegisterFile_Decode,
  input  logic                  enableReadDataMemory_Decode,
  input  logic                  enableWriteDataMemory_Decode,
  input  logic [DATA_WIDTH-1:0] instruction_Decode,
  input  logic [1:0]            fowardSelectA_FowardingUnit,
  input  logic [1:0]            fowardSelectB_FowardingUnit,
  input  logic [DATA_WIDTH-1:0] resultALU_MemoryAccess,
  input  logic [DATA_WIDTH-1:0] dataWriteBack_WriteBack,
  output logic                  stall_Execute,
  output logic                  enableWriteRegisterFile_Execute,
  output logic [4:0]            addressWriteRegisterFile_Execute,
  output logic                  controlSignalWriteFromDataMemoryRegisterFile_Execute,
  output logic [DATA_WIDTH-1:0] resultALU_Execute,
  output logic                  enableReadDataMemory_Execute,
  output logic                  enableWriteDataMemory_Execute,
  output logic [DATA_WIDTH-1:0] dataToWriteDataMemory_Execute,
  output logic [DATA_WIDTH-1:0] instruction_Execute
);
  localparam logic [3:0] ALU_AND  = 4'b0000, ALU_OR   = 4'b0001, ALU_ADD  = 4'b0010, ALU_MFLO = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110, ALU_SLT  = 4'b0111, ALU_SLL  = 4'b1000, ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010, ALU_LUI  = 4'b1011, ALU_NOR  = 4'b1100, ALU_MULT = 4'b1101;
  localparam logic [3:0] ALU_DIV  = 4'b1110, ALU_MFHI = 4'b1111;

  logic [31:0] operandA_s, rtForward_s, operandB_s, aluResult_s, hiValue_s, loValue_s;
  logic [4:0]  shamt_s;

  assign shamt_s    = instruction_Decode[10:6];
  assign operandB_s = controlSignalAluSource_Decode ? immediateExtended_Decode : rtForward_s;

  // Forwarding muxes; select 11 falls back to the register-file value
  always_comb begin
    operandA_s  = dataReadRegister1_Decode;
    rtForward_s = dataReadRegister2_Decode;
    case (fowardSelectA_FowardingUnit)
      2'b01:   operandA_s = resultALU_MemoryAccess;
      2'b10:   operandA_s = dataWriteBack_WriteBack;
      default: operandA_s = dataReadRegister1_Decode;
    endcase
    case (fowardSelectB_FowardingUnit)
      2'b01:   rtForward_s = resultALU_MemoryAccess;
      2'b10:   rtForward_s = dataWriteBack_WriteBack;
      default: rtForward_s = dataReadRegister2_Decode;
    endcase
  end

  // ALU; MULT/DIV themselves carry no result into EX/MEM
  always_comb begin
    aluResult_s = 32'h0000_0000;
    case (aluControl_Decode)
      ALU_AND:  aluResult_s = operandA_s & operandB_s;
      ALU_OR:   aluResult_s = operandA_s | operandB_s;
      ALU_ADD:  aluResult_s = operandA_s + operandB_s;
      ALU_SUB:  aluResult_s = operandA_s - operandB_s;
      ALU_SLT:  aluResult_s = {31'h0000_0000, ($signed(operandA_s) < $signed(operandB_s))};
      ALU_NOR:  aluResult_s = ~(operandA_s | operandB_s);
      ALU_SLL:  aluResult_s = operandB_s << shamt_s;
      ALU_SRL:  aluResult_s = operandB_s >> shamt_s;
      ALU_SRA:  aluResult_s = $signed(operandB_s) >>> shamt_s;
      ALU_LUI:  aluResult_s = {operandB_s[15:0], 16'h0000};
      ALU_MFHI: aluResult_s = hiValue_s;
      ALU_MFLO: aluResult_s = loValue_s;
      ALU_MULT, ALU_DIV: aluResult_s = 32'h0000_0000;
      default:  aluResult_s = 32'h0000_0000;
    endcase
  end

`ifdef MIPS_MULDIV_EN
  localparam int CNT_W = $clog2(MULDIV_CYCLES);
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} mulDivState_t;

  mulDivState_t state_r, stateNext_s;
  logic [CNT_W-1:0] count_r;
  logic [63:0] acc_r, stepAcc_s, product_s;
  logic [31:0] operandMag_r, magA_s, magB_s, hi_r, lo_r, quotient_s, remainder_s;
  logic [32:0] partial_s, difference_s;
  logic        isDiv_r, negQuot_r, negRem_r, divZero_r, isMulDiv_s, stall_s;

  assign isMulDiv_s = (aluControl_Decode == ALU_MULT) || (aluControl_Decode == ALU_DIV);
  assign magA_s     = operandA_s[31] ? (32'h0000_0000 - operandA_s) : operandA_s;
  assign magB_s     = operandB_s[31] ? (32'h0000_0000 - operandB_s) : operandB_s;
  assign hiValue_s  = hi_r;
  assign loValue_s  = lo_r;

  // MULT/DIV control state register
  always_ff @(posedge clock or posedge resetMachine) begin
    if (resetMachine) state_r <= IDLE;
    else              state_r <= stateNext_s;
  end

  // Next state and upstream stall
  always_comb begin
    stateNext_s = state_r;
    stall_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (isMulDiv_s) begin
          stateNext_s = BUSY;
          stall_s     = 1'b1;
        end else begin
          stateNext_s = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        if (count_r == {CNT_W{1'b0}}) stateNext_s = DONE;
        else                          stateNext_s = BUSY;
      end
      DONE:    stateNext_s = IDLE;
      default: stateNext_s = IDLE;
    endcase
  end

  // Reset must release the pipeline at once, even if a MULT/DIV is still presented
  assign stall_Execute = stall_s & ~resetMachine;

  // One shift-add (MULT) or restoring-subtract (DIV) step, plus sign correction of the final magnitudes
  always_comb begin
    partial_s    = 33'h0_0000_0000;
    difference_s = 33'h0_0000_0000;
    stepAcc_s    = acc_r;
    if (isDiv_r) begin
      partial_s    = {acc_r[63:32], acc_r[31]};
      difference_s = partial_s - {1'b0, operandMag_r};
      if (partial_s >= {1'b0, operandMag_r}) stepAcc_s = {difference_s[31:0], acc_r[30:0], 1'b1};
      else                                   stepAcc_s = {partial_s[31:0], acc_r[30:0], 1'b0};
    end else begin
      partial_s = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, operandMag_r} : 33'h0_0000_0000);
      stepAcc_s = {partial_s, acc_r[31:1]};
    end
    product_s   = negQuot_r ? (64'h0 - acc_r) : acc_r;
    quotient_s  = divZero_r ? 32'hFFFF_FFFF : (negQuot_r ? (32'h0000_0000 - acc_r[31:0]) : acc_r[31:0]);
    remainder_s = negRem_r ? (32'h0000_0000 - acc_r[63:32]) : acc_r[63:32];
  end

  // Multiply/divide datapath and HI/LO
  always_ff @(posedge clock or posedge resetMachine) begin
    if (resetMachine) begin
      count_r      <= {CNT_W{1'b0}};
      acc_r        <= 64'h0;
      operandMag_r <= 32'h0000_0000;
      isDiv_r      <= 1'b0;
      negQuot_r    <= 1'b0;
      negRem_r     <= 1'b0;
      divZero_r    <= 1'b0;
      hi_r         <= 32'h0000_0000;
      lo_r         <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (isMulDiv_s) begin
            isDiv_r   <= (aluControl_Decode == ALU_DIV);
            negQuot_r <= operandA_s[31] ^ operandB_s[31];
            negRem_r  <= operandA_s[31];
            divZero_r <= (aluControl_Decode == ALU_DIV) && (operandB_s == 32'h0000_0000);
            count_r   <= CNT_W'(MULDIV_CYCLES - 1);
            if (aluControl_Decode == ALU_DIV) begin
              acc_r        <= {32'h0000_0000, magA_s};
              operandMag_r <= magB_s;
            end else begin
              acc_r        <= {32'h0000_0000, magB_s};
              operandMag_r <= magA_s;
            end
          end
        end
        BUSY: begin
          acc_r   <= stepAcc_s;
          count_r <= count_r - CNT_W'(1);
        end
        DONE: begin
          hi_r <= isDiv_r ? remainder_s : product_s[63:32];
          lo_r <= isDiv_r ? quotient_s : product_s[31:0];
        end
        default: count_r <= {CNT_W{1'b0}};
      endcase
    end
  end
`else
  assign stall_Execute = 1'b0;
  assign hiValue_s     = 32'h0000_0000;
  assign loValue_s     = 32'h0000_0000;
`endif

  // EX/MEM pipeline register; a stall inserts a bubble
  always_ff @(posedge clock or posedge resetMachine) begin
    if (resetMachine || stall_Execute) begin
      enableWriteRegisterFile_Execute                      <= 1'b0;
      addressWriteRegisterFile_Execute                     <= 5'd0;
      controlSignalWriteFromDataMemoryRegisterFile_Execute <= 1'b0;
      resultALU_Execute                                    <= 32'h0000_0000;
      enableReadDataMemory_Execute                         <= 1'b0;
      enableWriteDataMemory_Execute                        <= 1'b0;
      dataToWriteDataMemory_Execute                        <= 32'h0000_0000;
      instruction_Execute                                  <= 32'h0000_0000;
    end else begin
      enableWriteRegisterFile_Execute                      <= enableWriteRegisterFile_Decode;
      addressWriteRegisterFile_Execute                     <= addressWriteRegisterFile_Decode;
      controlSignalWriteFromDataMemoryRegisterFile_Execute <= controlSignalWriteFromDataMemoryRegisterFile_Decode;
      resultALU_Execute                                    <= aluResult_s;
      enableReadDataMemory_Execute                         <= enableReadDataMemory_Decode;
      enableWriteDataMemory_Execute                        <= enableWriteDataMemory_Decode;
      dataToWriteDataMemory_Execute                        <= rtForward_s;
      instruction_Execute                                  <= instruction_Decode;
    end
  end
endmodule

// File: tb/tb_execute_stage_mips.sv
// Self-checking bench for execute_stage_mips: table-driven ALU/forwarding vectors plus
// hand-written MULT/DIV and reset sequences (expectations follow MIPS_MULDIV_EN).
module tb_execute_stage_mips;
  logic        clock = 1'b0;
  logic        resetMachine;
  logic [31:0] rs, rt, imm, instr, memFwd, wbData;
  logic [3:0]  aluCtl;
  logic        aluSrc, wen, memToReg, rdEn, wrEn;
  logic [4:0]  waddr;
  logic [1:0]  fwdA, fwdB;
  logic        stall, wenEx, memToRegEx, rdEx, wrEx;
  logic [4:0]  waddrEx;
  logic [31:0] resEx, storeEx, instrEx;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  execute_stage_mips dut (
    .clock(clock), .resetMachine(resetMachine),
    .dataReadRegister1_Decode(rs), .dataReadRegister2_Decode(rt), .immediateExtended_Decode(imm),
    .aluControl_Decode(aluCtl), .controlSignalAluSource_Decode(aluSrc),
    .enableWriteRegisterFile_Decode(wen), .addressWriteRegisterFile_Decode(waddr),
    .controlSignalWriteFromDataMemoryRegisterFile_Decode(memToReg),
    .enableReadDataMemory_Decode(rdEn), .enableWriteDataMemory_Decode(wrEn),
    .instruction_Decode(instr), .fowardSelectA_FowardingUnit(fwdA), .fowardSelectB_FowardingUnit(fwdB),
    .resultALU_MemoryAccess(memFwd), .dataWriteBack_WriteBack(wbData),
    .stall_Execute(stall), .enableWriteRegisterFile_Execute(wenEx), .addressWriteRegisterFile_Execute(waddrEx),
    .controlSignalWriteFromDataMemoryRegisterFile_Execute(memToRegEx), .resultALU_Execute(resEx),
    .enableReadDataMemory_Execute(rdEx), .enableWriteDataMemory_Execute(wrEx),
    .dataToWriteDataMemory_Execute(storeEx), .instruction_Execute(instrEx)
  );

  typedef struct {
    logic [3:0]  alu;
    logic        src;
    logic [31:0] rs, rt, imm;
    logic [1:0]  fa, fb;
    logic [31:0] mem, wb;
    logic [4:0]  shamt;
    logic [31:0] expRes, expStore;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] alu, input logic src, input logic [31:0] a, b, im,
                              input logic [1:0] fa, fb, input logic [31:0] mem, wb,
                              input logic [4:0] sh, input logic [31:0] expRes, expStore);
    vec_t v;
    v.alu = alu; v.src = src; v.rs = a; v.rt = b; v.imm = im; v.fa = fa; v.fb = fb;
    v.mem = mem; v.wb = wb; v.shamt = sh; v.expRes = expRes; v.expStore = expStore;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    rs = 32'h0; rt = 32'h0; imm = 32'h0; instr = 32'h0; memFwd = 32'h0; wbData = 32'h0;
    aluCtl = 4'b0000; aluSrc = 1'b0; wen = 1'b0; memToReg = 1'b0; rdEn = 1'b0; wrEn = 1'b0;
    waddr = 5'd0; fwdA = 2'b00; fwdB = 2'b00;
  endtask

  // Presents a MULT/DIV, counts stall cycles and bubbles, then reads HI and LO back via MFHI/MFLO
  task automatic mulDivOp(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int expStalls, input logic [31:0] expHi, input logic [31:0] expLo);
    int n;
    int bad;
    clearInputs();
    aluCtl = op; rs = a; rt = b; wen = 1'b1; waddr = 5'd9; instr = 32'h0123_0018;
    n = 0;
    bad = 0;
    #1;
    while (stall === 1'b1 && n < 40) begin
      n++;
      tick();
      if (resEx !== 32'h0 || wenEx !== 1'b0 || waddrEx !== 5'd0 || instrEx !== 32'h0) bad++;
    end
    check32({name, " stallCycles"}, 32'(n), 32'(expStalls));
    check32({name, " bubbles"}, 32'(bad), 32'd0);
    tick();
    check32({name, " advanceResult"}, resEx, 32'h0);
    check32({name, " advanceWen"}, {31'h0, wenEx}, 32'd1);
    check32({name, " advanceInstr"}, instrEx, 32'h0123_0018);
    clearInputs();
    aluCtl = 4'b1111;
    tick();
    check32({name, " MFHI"}, resEx, expHi);
    aluCtl = 4'b0011;
    tick();
    check32({name, " MFLO"}, resEx, expLo);
  endtask

  initial begin
    clearInputs();
    resetMachine = 1'b1;
    #1;
    check32("resetResult", resEx, 32'h0);
    check32("resetInstr", instrEx, 32'h0);
    check32("resetCtl", {27'h0, wenEx, memToRegEx, rdEx, wrEx, 1'b0}, 32'h0);
    check32("resetAddr", {27'h0, waddrEx}, 32'h0);
    check32("resetStall", {31'h0, stall}, 32'h0);
    tick();
    tick();
    @(negedge clock);
    resetMachine = 1'b0;
    tick();

    //        alu      src   rs            rt            imm           fa     fb     mem           wb            sh     expRes        expStore
    vecs.push_back(mk(4'b0010, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 32'h8000_0000, 32'h0000_0001));
    vecs.push_back(mk(4'b0110, 1'b0, 32'h0000_0100, 32'h0000_0200, 32'h0, 2'b01, 2'b10, 32'h5, 32'h3, 5'd0, 32'h0000_0002, 32'h0000_0003));
    vecs.push_back(mk(4'b0111, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0000_0001, 32'h0000_0001));
    vecs.push_back(mk(4'b0111, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0000_0000, 32'hFFFF_FFFF));
    vecs.push_back(mk(4'b1010, 1'b0, 32'h0,         32'h8000_0000, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd4, 32'hF800_0000, 32'h8000_0000));
    vecs.push_back(mk(4'b1001, 1'b0, 32'h0,         32'h8000_0000, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd4, 32'h0800_0000, 32'h8000_0000));
    vecs.push_back(mk(4'b1000, 1'b0, 32'h0,         32'h0000_0001, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd31, 32'h8000_0000, 32'h0000_0001));
    vecs.push_back(mk(4'b0000, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 32'hF000_F000, 32'hFF00_FF00));
    vecs.push_back(mk(4'b0001, 1'b1, 32'hF0F0_F0F0, 32'h1234_5678, 32'hF, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 32'hF0F0_F0FF, 32'h1234_5678));
    vecs.push_back(mk(4'b1100, 1'b0, 32'h0,         32'h0F0F_0F0F, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 32'hF0F0_F0F0, 32'h0F0F_0F0F));
    vecs.push_back(mk(4'b1011, 1'b1, 32'h0,         32'h0,         32'h0000_1234, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 32'h1234_0000, 32'h0));
    vecs.push_back(mk(4'b0110, 1'b0, 32'h0,         32'h0000_0001, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001));
    vecs.push_back(mk(4'b0010, 1'b0, 32'h0000_0010, 32'h0000_0005, 32'h0, 2'b11, 2'b11, 32'h100, 32'h200, 5'd0, 32'h0000_0015, 32'h0000_0005));
    vecs.push_back(mk(4'b0010, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0, 2'b10, 2'b01, 32'h20, 32'h10, 5'd0, 32'h0000_0030, 32'h0000_0020));
    vecs.push_back(mk(4'b0100, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0000_0000, 32'hFFFF_FFFF));
    vecs.push_back(mk(4'b0010, 1'b1, 32'h0000_1000, 32'h0000_0007, 32'hFFFF_FFFF, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0000_0FFF, 32'h0000_0007));

    for (int i = 0; i < vecs.size(); i++) begin
      logic [31:0] expInstr;
      expInstr = 32'hA500_0000 | (32'(vecs[i].shamt) << 6) | 32'(i);
      aluCtl = vecs[i].alu; aluSrc = vecs[i].src; rs = vecs[i].rs; rt = vecs[i].rt; imm = vecs[i].imm;
      fwdA = vecs[i].fa; fwdB = vecs[i].fb; memFwd = vecs[i].mem; wbData = vecs[i].wb; instr = expInstr;
      wen = i[0]; memToReg = i[1]; rdEn = i[2]; wrEn = ~i[0]; waddr = 5'(i + 3);
      #1;
      check32($sformatf("vec%0d stall", i), {31'h0, stall}, 32'h0);
      tick();
      check32($sformatf("vec%0d result", i), resEx, vecs[i].expRes);
      check32($sformatf("vec%0d store", i), storeEx, vecs[i].expStore);
      check32($sformatf("vec%0d instr", i), instrEx, expInstr);
      check32($sformatf("vec%0d ctl", i), {26'h0, waddrEx, wenEx},
              {26'h0, 5'(i + 3), i[0]});
      check32($sformatf("vec%0d mem", i), {29'h0, memToRegEx, rdEx, wrEx}, {29'h0, i[1], i[2], ~i[0]});
    end

    // Asynchronous reset clears a populated EX/MEM register without a clock edge
    @(negedge clock);
    resetMachine = 1'b1;
    #1;
    check32("asyncResetResult", resEx, 32'h0);
    check32("asyncResetInstr", instrEx, 32'h0);
    check32("asyncResetStore", storeEx, 32'h0);
    @(negedge clock);
    resetMachine = 1'b0;
    tick();

`ifdef MIPS_MULDIV_EN
    mulDivOp("mult-3x7", 4'b1101, 32'hFFFF_FFFD, 32'h0000_0007, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    mulDivOp("multMax", 4'b1101, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 33, 32'h3FFF_FFFF, 32'h0000_0001);
    mulDivOp("div-7/2", 4'b1110, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    mulDivOp("div100/-7", 4'b1110, 32'h0000_0064, 32'hFFFF_FFF9, 33, 32'h0000_0002, 32'hFFFF_FFF2);
    mulDivOp("div9/0", 4'b1110, 32'h0000_0009, 32'h0000_0000, 33, 32'h0000_0009, 32'hFFFF_FFFF);

    // Reset in the middle of a MULT aborts it and clears HI/LO left by the previous DIV
    clearInputs();
    aluCtl = 4'b1101; rs = 32'h5; rt = 32'h5;
    for (int c = 0; c < 11; c++) tick();
    check32("midOpStallBefore", {31'h0, stall}, 32'h1);
    resetMachine = 1'b1;
    aluCtl = 4'b0011;
    #1;
    check32("midOpStallDrop", {31'h0, stall}, 32'h0);
    check32("midOpResult", resEx, 32'h0);
    @(negedge clock);
    resetMachine = 1'b0;
    tick();
    check32("midOpMFLO", resEx, 32'h0);
    check32("midOpStallAfter", {31'h0, stall}, 32'h0);
    aluCtl = 4'b1111;
    tick();
    check32("midOpMFHI", resEx, 32'h0);
`else
    mulDivOp("multNop", 4'b1101, 32'hFFFF_FFFD, 32'h0000_0007, 0, 32'h0, 32'h0);
    mulDivOp("divNop", 4'b1110, 32'h0000_0009, 32'h0000_0000, 0, 32'h0, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
